// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Oversampling UART receiver with programmable baud divisor,
//               runtime parity / stop-bit selection and a first-word-fall-
//               through receive FIFO with valid/ready pop and sticky overrun.
//               Optional build macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3
//               majority bit decisions instead of a single mid-bit sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              rx_en,
   input  logic                              rxd,
   input  logic [DIV_WIDTH-1:0]              baud_div,
   input  logic [1:0]                        parity_mode,
   input  logic                              stop_bits,
   output logic [DATA_BITS-1:0]              rx_data,
   output logic                              rx_perr,
   output logic                              rx_ferr,
   output logic                              rx_valid,
   input  logic                              rx_ready,
   output logic                              rx_overrun,
   input  logic                              ovr_clr,
   output logic                              rx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int c_OS_W  = $clog2(OVERSAMPLE);
   localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int c_ENT_W = DATA_BITS + 2;

   localparam logic [c_OS_W-1:0]  c_D_START  = c_OS_W'(OVERSAMPLE/2 - 1);
   localparam logic [c_OS_W-1:0]  c_D_BIT    = c_OS_W'(OVERSAMPLE - 1);
   localparam logic [c_OS_W-1:0]  c_OS_ONE   = c_OS_W'(1);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

   localparam logic [2:0] c_S_IDLE   = 3'd0;
   localparam logic [2:0] c_S_START  = 3'd1;
   localparam logic [2:0] c_S_DATA   = 3'd2;
   localparam logic [2:0] c_S_PARITY = 3'd3;
   localparam logic [2:0] c_S_STOP1  = 3'd4;
   localparam logic [2:0] c_S_STOP2  = 3'd5;

   logic                 r_rxd_s1, r_rxd_s2;
   logic [DIV_WIDTH-1:0] r_div_cnt, r_div_lat;
   logic [1:0]           r_par_mode;
   logic                 r_stop2;
   logic [2:0]           r_state;
   logic [c_OS_W-1:0]    r_os_cnt;
   logic [c_IDX_W-1:0]   r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr, r_ferr;

   logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic                 r_overrun;

   logic                 w_tick, w_bit, w_at_d, w_par_en, w_par_exp;
   logic [c_OS_W-1:0]    w_dcnt;
   logic                 w_push, w_pop, w_wr, w_drop, w_full, w_empty;
   logic [c_ENT_W-1:0]   w_entry, w_head;

   // Two-flop synchroniser for the asynchronous serial pad, idles high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rxd_s1 <= 1'b1;
         r_rxd_s2 <= 1'b1;
      end else begin
         r_rxd_s1 <= rxd;
         r_rxd_s2 <= r_rxd_s1;
      end
   end

   assign w_tick = rx_en && (r_div_cnt == '0);

   // Sample-tick down-counter; parked at the divisor while disabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_div_cnt <= '0;
      else if (!rx_en)
         r_div_cnt <= baud_div;
      else if (w_tick)
         r_div_cnt <= (r_state == c_S_IDLE) ? baud_div : r_div_lat;
      else
         r_div_cnt <= r_div_cnt - 1'b1;
   end

   // Line configuration is captured only between frames
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_lat  <= '0;
         r_par_mode <= 2'b00;
         r_stop2    <= 1'b0;
      end else if (r_state == c_S_IDLE) begin
         r_div_lat  <= baud_div;
         r_par_mode <= parity_mode;
         r_stop2    <= stop_bits;
      end
   end

   assign w_dcnt    = (r_state == c_S_START) ? c_D_START : c_D_BIT;
   assign w_at_d    = (r_os_cnt == w_dcnt);
   assign w_par_en  = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
   assign w_par_exp = (^r_shift) ^ (r_par_mode == 2'b10);

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic r_vote0, r_vote1;

   // Capture the two samples preceding the deciding tick of each bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vote0 <= 1'b1;
         r_vote1 <= 1'b1;
      end else if (w_tick && (r_state != c_S_IDLE)) begin
         if (r_os_cnt == w_dcnt - c_OS_ONE - c_OS_ONE)
            r_vote0 <= r_rxd_s2;
         if (r_os_cnt == w_dcnt - c_OS_ONE)
            r_vote1 <= r_rxd_s2;
      end
   end

   assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & r_rxd_s2) | (r_vote1 & r_rxd_s2);
`else
   assign w_bit = r_rxd_s2;
`endif

   // The frame completes on the deciding tick of its last stop bit
   assign w_push  = w_tick && w_at_d &&
                    (((r_state == c_S_STOP1) && !r_stop2) || (r_state == c_S_STOP2));
   assign w_entry = {r_ferr | ~w_bit, r_perr, r_shift};

   // Frame FSM; dropping rx_en abandons any partial frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_S_IDLE;
         r_os_cnt  <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
      end else if (!rx_en) begin
         r_state  <= c_S_IDLE;
         r_os_cnt <= '0;
      end else if (w_tick) begin
         if (r_state != c_S_IDLE)
            r_os_cnt <= w_at_d ? '0 : r_os_cnt + c_OS_ONE;
         case (r_state)
            c_S_IDLE: begin
               if (!r_rxd_s2) begin
                  r_state  <= c_S_START;
                  r_os_cnt <= '0;
                  r_perr   <= 1'b0;
                  r_ferr   <= 1'b0;
               end
            end
            c_S_START: begin
               if (w_at_d) begin
                  r_state   <= w_bit ? c_S_IDLE : c_S_DATA;
                  r_bit_idx <= '0;
               end
            end
            c_S_DATA: begin
               if (w_at_d) begin
                  r_shift[r_bit_idx] <= w_bit;
                  if (r_bit_idx == c_LAST_IDX)
                     r_state <= w_par_en ? c_S_PARITY : c_S_STOP1;
                  else
                     r_bit_idx <= r_bit_idx + c_IDX_ONE;
               end
            end
            c_S_PARITY: begin
               if (w_at_d) begin
                  r_perr  <= (w_bit != w_par_exp);
                  r_state <= c_S_STOP1;
               end
            end
            c_S_STOP1: begin
               if (w_at_d) begin
                  r_ferr  <= r_ferr | ~w_bit;
                  r_state <= r_stop2 ? c_S_STOP2 : c_S_IDLE;
               end
            end
            c_S_STOP2: begin
               if (w_at_d)
                  r_state <= c_S_IDLE;
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   assign w_full  = (r_count == c_FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && rx_ready;
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   // FIFO storage; contents are only observed while non-empty
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= w_entry;
   end

   // FIFO pointers, occupancy and sticky overrun (new overrun beats clear)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         if (w_wr && !w_pop)
            r_count <= r_count + c_CNT_ONE;
         else if (w_pop && !w_wr)
            r_count <= r_count - c_CNT_ONE;
         if (w_drop)
            r_overrun <= 1'b1;
         else if (ovr_clr)
            r_overrun <= 1'b0;
      end
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign rx_valid   = !w_empty;
   assign rx_data    = rx_valid ? w_head[DATA_BITS-1:0] : '0;
   assign rx_perr    = rx_valid & w_head[DATA_BITS];
   assign rx_ferr    = rx_valid & w_head[DATA_BITS+1];
   assign rx_overrun = r_overrun;
   assign rx_busy    = (r_state != c_S_IDLE);
   assign fifo_count = r_count;

endmodule
`default_nettype wire
